// File: rtl/fpa.sv
// Single-precision floating-point adder with one registered output stage.
// Denormal inputs are flushed to zero; rounding is to nearest, ties to even.
module fpa #(
    parameter int unsigned EXPONENT_LENGTH = 8,
    parameter int unsigned MANTISSA_LENGTH = 23
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0] A,
    input  logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0] B,
    output logic [EXPONENT_LENGTH+MANTISSA_LENGTH:0] Sum,
    output logic                                     Cout,
    output logic                                     overflow,
    output logic                                     underflow,
    output logic                                     exception
);

    localparam int unsigned E  = EXPONENT_LENGTH;
    localparam int unsigned M  = MANTISSA_LENGTH;
    localparam int unsigned W  = E + M + 1;
    localparam int unsigned SW = M + 1;          // significand incl. hidden bit
    localparam int unsigned GW = SW + 3;         // significand + guard/round/sticky
    localparam int unsigned XW = 2 * SW + 2;     // alignment window

    localparam logic [E-1:0] EMAX = '1;

    logic          sa, sb, sl, ss;
    logic [E-1:0]  ea, eb, el, es, shamt;
    logic [M-1:0]  fa, fb;
    logic [SW-1:0] ma, mb, ml, ms;
    logic [XW-1:0] wide;
    logic          stk;
    logic [GW-1:0] op_l, op_s, dif, norm;
    logic [GW:0]   add;
    logic          eff_sub, carry;
    int            lz, exp_n;
    logic [SW-1:0] mant, mant_f;
    logic [SW:0]   mr;
    logic          rnd_up;
    logic          a_nan, b_nan, a_inf, b_inf;

    logic [W-1:0]  sum_d, sum_q;
    logic          cout_d, cout_q, ovf_d, ovf_q, udf_d, udf_q, exc_d, exc_q;

    // Unpack, align, add/subtract, normalize, round and resolve special cases.
    always_comb begin
        sa = A[W-1];
        ea = A[W-2:M];
        fa = A[M-1:0];
        sb = B[W-1];
        eb = B[W-2:M];
        fb = B[M-1:0];
        ma = (ea != '0) ? {1'b1, fa} : '0;
        mb = (eb != '0) ? {1'b1, fb} : '0;

        // Larger magnitude goes to the l-side so subtraction never goes negative.
        if ({ea, ma} >= {eb, mb}) begin
            sl = sa; el = ea; ml = ma;
            ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb;
            ss = sa; es = ea; ms = ma;
        end

        shamt = el - es;
        wide  = {ms, {(XW - SW){1'b0}}} >> shamt;
        stk   = (|wide[XW-SW-3:0]) | ((32'(shamt) >= XW) & (|ms));
        op_l  = {ml, 3'b000};
        op_s  = {wide[XW-1 -: SW], wide[XW-SW-1], wide[XW-SW-2], stk};

        eff_sub = sl ^ ss;
        add     = {1'b0, op_l} + {1'b0, op_s};
        dif     = op_l - op_s;
        carry   = 1'b0;
        lz      = int'(GW);
        norm    = '0;
        exp_n   = int'(el);

        if (!eff_sub) begin
            if (add[GW]) begin
                // Carry into the next binade: shift right and fold the lost bit into sticky.
                norm  = {add[GW:2], add[1] | add[0]};
                exp_n = int'(el) + 1;
                carry = 1'b1;
            end else begin
                norm = add[GW-1:0];
            end
        end else begin
            for (int i = 0; i < int'(GW); i++) begin
                if (dif[i]) lz = int'(GW) - 1 - i;
            end
            norm  = dif << lz;
            exp_n = int'(el) - lz;
        end

        mant   = norm[GW-1:3];
        rnd_up = norm[2] & (norm[1] | norm[0] | mant[0]);
        mr     = {1'b0, mant} + {{SW{1'b0}}, rnd_up};
        if (mr[SW]) begin
            mant_f = mr[SW:1];
            exp_n  = exp_n + 1;
        end else begin
            mant_f = mr[SW-1:0];
        end

        sum_d  = {sl, exp_n[E-1:0], mant_f[M-1:0]};
        cout_d = carry;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        exc_d  = 1'b0;

        if (exp_n >= int'(EMAX)) begin
            sum_d = {sl, EMAX, {M{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_n <= 0) begin
            sum_d = {sl, {(W - 1){1'b0}}};
            udf_d = 1'b1;
        end

        // Exact cancellation yields +0.
        if (eff_sub && dif == '0) begin
            sum_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (ea == '0 && eb == '0) begin
            sum_d  = {sa & sb, {(W - 1){1'b0}}};
            cout_d = 1'b0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end

        a_inf = (ea == EMAX) && (fa == '0);
        b_inf = (eb == EMAX) && (fb == '0);
        a_nan = (ea == EMAX) && (fa != '0);
        b_nan = (eb == EMAX) && (fb != '0);
        if (ea == EMAX || eb == EMAX) begin
            exc_d  = 1'b1;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                sum_d = {1'b0, EMAX, 1'b1, {(M - 1){1'b0}}};
            end else if (a_inf) begin
                sum_d = A;
            end else begin
                sum_d = B;
            end
        end
    end

    // Output register bank; result and flags update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            exc_q  <= exc_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_fpa.sv
// Directed bench for fpa: hand-computed vectors, reset behaviour and special operands.
module tb_fpa;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Sum;
    logic        Cout;
    logic        overflow;
    logic        underflow;
    logic        exception;

    int tests;
    int fails;

    fpa #(
        .EXPONENT_LENGTH(8),
        .MANTISSA_LENGTH(23)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Sum      (Sum),
        .Cout     (Cout),
        .overflow (overflow),
        .underflow(underflow),
        .exception(exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands on the falling edge, sample just after the next rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Flags packed as {Cout, overflow, underflow, exception}.
    function automatic logic [31:0] flags();
        return {28'h0, Cout, overflow, underflow, exception};
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        A     = 32'h0;
        B     = 32'h0;
        #2;
        check("reset_sum", Sum, 32'h0);
        check("reset_flags", flags(), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h40480000, 32'h40480000);
        check("carry_sum", Sum, 32'h40C80000);
        check("carry_flags", flags(), 32'h8);

        apply(32'h40200000, 32'h40A40000);
        check("diffexp_sum", Sum, 32'h40F40000);
        check("diffexp_flags", flags(), 32'h0);

        apply(32'h3D800000, 32'h3E000000);
        check("small_sum", Sum, 32'h3E400000);
        check("small_flags", flags(), 32'h0);

        apply(32'h40A80000, 32'hC0440000);
        check("mixed_sum", Sum, 32'h400C0000);
        check("mixed_flags", flags(), 32'h0);

        apply(32'hC0A80000, 32'hC0480000);
        check("negneg_sum", Sum, 32'hC1060000);
        check("negneg_cout", {31'h0, Cout}, 32'h1);

        apply(32'h7F7FFFFF, 32'h7F7FFFFF);
        check("ovf_sum", Sum, 32'h7F800000);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        check("ovf_others", {30'h0, underflow, exception}, 32'h0);

        apply(32'h00800000, 32'h80800001);
        check("udf_sum", Sum, 32'h80000000);
        check("udf_flags", flags(), 32'h2);

        apply(32'h3F800000, 32'hBF800000);
        check("cancel_sum", Sum, 32'h00000000);
        check("cancel_flags", flags(), 32'h0);

        apply(32'h7F800000, 32'hFF800000);
        check("infinf_sum", Sum, 32'h7FC00000);
        check("infinf_flags", flags(), 32'h1);

        apply(32'h7F800000, 32'h3F800000);
        check("infnum_sum", Sum, 32'h7F800000);
        check("infnum_flags", flags(), 32'h1);

        apply(32'h7FC12345, 32'h3F800000);
        check("nan_sum", Sum, 32'h7FC00000);

        apply(32'h80000000, 32'h80000000);
        check("negzero_sum", Sum, 32'h80000000);
        check("negzero_flags", flags(), 32'h0);

        apply(32'h80000000, 32'h00000000);
        check("mixzero_sum", Sum, 32'h00000000);

        // 1.0 + 2^-24 is an exact tie; stays at 1.0 (even).
        apply(32'h3F800000, 32'h33800000);
        check("tie_even_sum", Sum, 32'h3F800000);

        // (1 + 2^-23) + 2^-24 is a tie with odd LSB; rounds up.
        apply(32'h3F800001, 32'h33800000);
        check("tie_up_sum", Sum, 32'h3F800002);

        // Asynchronous reset between edges, held across a rising edge.
        apply(32'h40480000, 32'h40480000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_sum", Sum, 32'h0);
        check("midreset_flags", flags(), 32'h0);
        @(posedge clk);
        #1;
        check("heldreset_sum", Sum, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h40480000, 32'h40480000);
        check("postreset_sum", Sum, 32'h40C80000);
        check("postreset_flags", flags(), 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
